// File: rtl/rv32i_types.sv
// Shared RV32I core types: CDB entry layout, FU id and program-order widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv32i_types;

  localparam int TOTAL_FU = 4;
  localparam int FU_ID_W  = 3;
  localparam int ORDER_W  = 6;
  localparam int REG_W    = 5;
  localparam int XLEN     = 32;

  typedef logic [FU_ID_W-1:0] fu_id_t;
  typedef logic [ORDER_W-1:0] order_t;

  typedef struct packed {
    fu_id_t           fu_id;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_rr_picker.sv
// Round-robin picker: first set request at or after ptr, ascending, wrapping mod N.
// Latency: purely combinational.
// Backpressure: none; caller decides whether the pick is consumed.
module cdb_rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W:0]   cand_w;
  logic [IDX_W-1:0] cand;

  // Walk N candidates starting at ptr; the first requester found wins.
  always_comb begin
    gnt    = '0;
    idx    = '0;
    any    = 1'b0;
    cand_w = '0;
    cand   = '0;
    for (int off = 0; off < N; off++) begin
      cand_w = {1'b0, ptr} + (IDX_W+1)'(off);
      if (cand_w >= (IDX_W+1)'(N)) begin
        cand_w = cand_w - (IDX_W+1)'(N);
      end
      cand = cand_w[IDX_W-1:0];
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    if (any) begin
      gnt[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one holding buffer per FU, one broadcast per cycle; CDB_AGE_PRIO_EN selects oldest-first, else round-robin.
// Latency: FU valid in cycle N -> buffered/granted N+1 -> cdb_valid N+2.
// Backpressure: fu_result_ack drops while the FU's buffer is full and not granted; flush and rst block acks.
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int NUM_FU = TOTAL_FU
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [NUM_FU-1:0]             fu_result_valid,
  input  cdb_entry_t [NUM_FU-1:0]       fu_result,
  input  order_t [NUM_FU-1:0]           fu_result_order,
  output logic [NUM_FU-1:0]             fu_result_ack,
  output logic                          cdb_valid,
  output cdb_entry_t                    cdb_data,
  output logic [$clog2(NUM_FU+1)-1:0]   cdb_pending
);

  localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int CNT_W = $clog2(NUM_FU+1);

  logic [NUM_FU-1:0] buf_valid;
  logic [NUM_FU-1:0] buf_valid_nxt;
  cdb_entry_t        buf_entry [NUM_FU];
  logic [IDX_W-1:0]  rr_ptr;

  logic [NUM_FU-1:0] pick_gnt;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;

  logic [NUM_FU-1:0] grant;
  logic              grant_any;
  logic [CNT_W-1:0]  pending_nxt;

`ifdef CDB_AGE_PRIO_EN
  order_t buf_order [NUM_FU];
  order_t best_order;
  logic   unused_rr_ptr;

  assign unused_rr_ptr = ^rr_ptr;

  // Oldest occupied buffer wins; strict compare keeps the lowest index on ties.
  always_comb begin
    pick_gnt   = '0;
    pick_idx   = '0;
    pick_any   = 1'b0;
    best_order = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (buf_valid[i] && (!pick_any || (buf_order[i] < best_order))) begin
        pick_any   = 1'b1;
        best_order = buf_order[i];
        pick_idx   = IDX_W'(i);
      end
    end
    if (pick_any) begin
      pick_gnt[pick_idx] = 1'b1;
    end
  end

  // Program order travels with the buffered entry.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (fu_result_ack[i]) begin
        buf_order[i] <= fu_result_order[i];
      end
    end
  end
`else
  logic unused_order;

  assign unused_order = ^fu_result_order;

  cdb_rr_picker #(
    .N     (NUM_FU),
    .IDX_W (IDX_W)
  ) u_picker (
    .req (buf_valid),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );
`endif

  // A flush cancels this cycle's grant so nothing reaches the CDB afterwards.
  always_comb begin
    grant     = flush ? '0 : pick_gnt;
    grant_any = pick_any && !flush;
  end

  // A buffer accepts when empty or when its current occupant is leaving this cycle.
  always_comb begin
    fu_result_ack = fu_result_valid & ~buf_valid | fu_result_valid & grant;
    if (flush || rst) begin
      fu_result_ack = '0;
    end
  end

  // Next occupancy: load wins over free, flush empties everything.
  always_comb begin
    buf_valid_nxt = (buf_valid & ~grant) | fu_result_ack;
    if (flush) begin
      buf_valid_nxt = '0;
    end
    pending_nxt = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      pending_nxt = pending_nxt + CNT_W'(buf_valid_nxt[i]);
    end
  end

  // Occupancy, pending count and the broadcast register.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid   <= '0;
      cdb_pending <= '0;
      cdb_valid   <= 1'b0;
      cdb_data    <= '0;
    end else begin
      buf_valid   <= buf_valid_nxt;
      cdb_pending <= pending_nxt;
      cdb_valid   <= grant_any;
      cdb_data    <= grant_any ? buf_entry[pick_idx] : '0;
    end
  end

  // Payload capture; fu_id is stamped with the buffer index, not trusted from the FU.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (fu_result_ack[i]) begin
        buf_entry[i]       <= fu_result[i];
        buf_entry[i].fu_id <= fu_id_t'(i);
      end
    end
  end

  // Pointer moves past the winner; in age mode it stays parked at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else begin
`ifdef CDB_AGE_PRIO_EN
      rr_ptr <= '0;
`else
      if (grant_any) begin
        rr_ptr <= (pick_idx == IDX_W'(NUM_FU-1)) ? '0 : pick_idx + IDX_W'(1);
      end
`endif
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter (NUM_FU=4, round-robin): directed scenarios plus random traffic vs a queue-level model.
// Latency: checks registered outputs at each negedge against the model state for that cycle.
// Backpressure: FUs hold an offer until acked; random flush and reset are mixed in.
module tb_cdb_arbiter;
  import rv32i_types::*;

  localparam int N  = 4;
  localparam int CW = $clog2(N+1);

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [N-1:0]     fu_result_valid;
  cdb_entry_t [N-1:0] fu_result;
  order_t [N-1:0]   fu_result_order;
  logic [N-1:0]     fu_result_ack;
  logic             cdb_valid;
  cdb_entry_t       cdb_data;
  logic [CW-1:0]    cdb_pending;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_FU(N)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .fu_result_valid (fu_result_valid),
    .fu_result       (fu_result),
    .fu_result_order (fu_result_order),
    .fu_result_ack   (fu_result_ack),
    .cdb_valid       (cdb_valid),
    .cdb_data        (cdb_data),
    .cdb_pending     (cdb_pending)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: what each FU slot holds, where the rotation starts, what is on the bus.
  bit         mb_valid [N];
  cdb_entry_t mb_entry [N];
  int         m_ptr;
  bit         m_cv;
  cdb_entry_t m_cd;

  // Last observed values, for directed expectations.
  logic [N-1:0] o_ack;
  logic         o_cv;
  cdb_entry_t   o_cd;
  int           o_pend;
  int           bcast = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic cdb_entry_t mk(input int fid, input int rd, input logic [31:0] d);
    cdb_entry_t e;
    e.fu_id = fu_id_t'(fid);
    e.rd    = 5'(rd);
    e.data  = d;
    return e;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      mb_valid[i] = 1'b0;
      mb_entry[i] = '0;
    end
    m_ptr = 0;
    m_cv  = 1'b0;
    m_cd  = '0;
  endtask

  // One clock: compare at negedge, advance the model, return #1 after posedge.
  task automatic cycle();
    int           w;
    int           cnt;
    logic [N-1:0] eack;
    cdb_entry_t   e;
    @(negedge clk);
    w = -1;
    if (!rst && !flush) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (w < 0 && mb_valid[j]) w = j;
      end
    end
    cnt = 0;
    for (int i = 0; i < N; i++) cnt += int'(mb_valid[i]);
    for (int i = 0; i < N; i++) begin
      eack[i] = fu_result_valid[i] && !rst && !flush && (!mb_valid[i] || w == i);
    end
    chk("ack", 64'(fu_result_ack), 64'(eack));
    chk("cdb_valid", 64'(cdb_valid), 64'(m_cv));
    chk("cdb_data", 64'(cdb_data), 64'(m_cd));
    chk("pending", 64'(cdb_pending), 64'(cnt));
    o_ack  = fu_result_ack;
    o_cv   = cdb_valid;
    o_cd   = cdb_data;
    o_pend = int'(cdb_pending);
    if (cdb_valid === 1'b1) bcast++;
    if (rst) begin
      model_clear();
    end else if (flush) begin
      for (int i = 0; i < N; i++) mb_valid[i] = 1'b0;
      m_cv = 1'b0;
      m_cd = '0;
    end else begin
      if (w >= 0) begin
        m_cv        = 1'b1;
        m_cd        = mb_entry[w];
        mb_valid[w] = 1'b0;
        m_ptr       = (w + 1) % N;
      end else begin
        m_cv = 1'b0;
        m_cd = '0;
      end
      for (int i = 0; i < N; i++) begin
        if (eack[i]) begin
          e           = fu_result[i];
          e.fu_id     = fu_id_t'(i);
          mb_valid[i] = 1'b1;
          mb_entry[i] = e;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic contention(input string tag);
    fu_result_valid = '1;
    for (int i = 0; i < N; i++) fu_result[i] = mk(7, i + 1, 32'h100 + i);
    cycle();
    fu_result_valid = '0;
    cycle();
    chk({tag, "_pend4"}, 64'(o_pend), 64'd4);
    for (int k = 0; k < N; k++) begin
      cycle();
      chk({tag, "_id"}, 64'(o_cd.fu_id), 64'(k));
      chk({tag, "_pend"}, 64'(o_pend), 64'(3 - k));
    end
  endtask

  bit offering [N];
  int b0;

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    fu_result_valid = '0;
    fu_result = '0;
    fu_result_order = '0;
    repeat (2) @(posedge clk);
    #1;
    model_clear();

    // Reset state, with requests present: no acks allowed.
    fu_result_valid = '1;
    cycle();
    chk("rst_ack", 64'(o_ack), 64'd0);
    rst = 1'b0;
    fu_result_valid = '0;
    cycle();

    // All four buffers full from rr_ptr=0.
    contention("cont");

    // Single result through FU2; fu_id comes from the slot, not the FU.
    fu_result_valid = 4'b0100;
    fu_result[2] = mk(7, 5, 32'hDEADBEEF);
    cycle();
    chk("single_ack", 64'(o_ack[2]), 64'd1);
    fu_result_valid = '0;
    cycle();
    cycle();
    chk("single_cv", 64'(o_cv), 64'd1);
    chk("single_data", 64'(o_cd), 64'(mk(2, 5, 32'hDEADBEEF)));
    cycle();
    chk("single_cv_off", 64'(o_cv), 64'd0);

    // Back-pressure on FU1; second entry has rd=0 and must still be broadcast.
    b0 = bcast;
    fu_result_valid = 4'b0011;
    fu_result[0] = mk(0, 3, 32'h0);
    fu_result[1] = mk(0, 9, 32'hAAAA0001);
    cycle();
    fu_result_valid = 4'b0010;
    fu_result[1] = mk(0, 0, 32'hBBBB0002);
    cycle();
    chk("bp_hold", 64'(o_ack[1]), 64'd0);
    cycle();
    chk("bp_take", 64'(o_ack[1]), 64'd1);
    fu_result_valid = '0;
    cycle();
    chk("bp_old", 64'(o_cd), 64'(mk(1, 9, 32'hAAAA0001)));
    cycle();
    chk("bp_new", 64'(o_cd), 64'(mk(1, 0, 32'hBBBB0002)));
    cycle();
    chk("bp_count", 64'(bcast - b0), 64'd3);

    // Flush with three buffers full.
    fu_result_valid = 4'b0111;
    for (int i = 0; i < N; i++) fu_result[i] = mk(0, 10 + i, 32'hF0 + i);
    cycle();
    fu_result_valid = '0;
    flush = 1'b1;
    b0 = bcast;
    cycle();
    chk("fl_pend_before", 64'(o_pend), 64'd3);
    flush = 1'b0;
    cycle();
    chk("fl_cv", 64'(o_cv), 64'd0);
    chk("fl_pend", 64'(o_pend), 64'd0);
    repeat (4) cycle();
    chk("fl_none", 64'(bcast - b0), 64'd0);

    // Reset mid-run with two buffers full.
    fu_result_valid = 4'b1001;
    for (int i = 0; i < N; i++) fu_result[i] = mk(0, 20 + i, 32'hC0 + i);
    cycle();
    rst = 1'b1;
    fu_result_valid = 4'b0010;
    b0 = bcast;
    cycle();
    chk("mr_pend_before", 64'(o_pend), 64'd2);
    chk("mr_ack", 64'(o_ack), 64'd0);
    rst = 1'b0;
    fu_result_valid = '0;
    cycle();
    chk("mr_cv", 64'(o_cv), 64'd0);
    chk("mr_data", 64'(o_cd), 64'd0);
    chk("mr_pend", 64'(o_pend), 64'd0);
    repeat (3) cycle();
    chk("mr_none", 64'(bcast - b0), 64'd0);
    // Pointer back at zero: FU0 first again.
    contention("cont2");

    // Random traffic; FUs hold offers until acked.
    for (int i = 0; i < N; i++) offering[i] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!offering[i] && ($urandom_range(0, 9) < 4)) begin
          offering[i] = 1'b1;
          fu_result[i] = mk($urandom_range(0, 7),
                            ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 31),
                            $urandom);
        end
        fu_result_valid[i] = offering[i];
        fu_result_order[i] = order_t'($urandom);
      end
      flush = ($urandom_range(0, 31) == 0);
      rst   = ($urandom_range(0, 96) == 0);
      cycle();
      for (int i = 0; i < N; i++) begin
        if (o_ack[i]) offering[i] = 1'b0;
      end
    end
    flush = 1'b0;
    rst = 1'b0;
    fu_result_valid = '0;
    repeat (6) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
